// File: rtl/ps2_host_transmitter.sv
`default_nettype none
// ============================================================================
// ps2_host_transmitter: PS/2 host-to-device command sender (RTS, frame, ACK).
// Revision: 1.0
// ============================================================================
module ps2_host_transmitter #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int INHIBIT_US      = 100,
  parameter int TIMEOUT_US      = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic       ps2ClkDriveLow,
  output logic       ps2DataDriveLow,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int c_INHIBIT_CYC = CLOCK_FREQUENCY / 1000000 * INHIBIT_US;
  localparam int c_TIMEOUT_CYC = CLOCK_FREQUENCY / 1000000 * TIMEOUT_US;
  localparam int c_INH_W       = $clog2(c_INHIBIT_CYC) + 1;
  localparam int c_TO_W        = $clog2(c_TIMEOUT_CYC) + 1;
  localparam int c_BIT_W       = $clog2(10) + 1;

  localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(c_INHIBIT_CYC - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(c_TIMEOUT_CYC - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(9);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQUEST   = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t              r_state;
  logic [10:0]         r_shift;
  logic [c_INH_W-1:0]  r_inh_cnt;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic                r_ack_ok;
  logic                r_clk_low;
  logic                r_data_low;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  logic                r_clk_meta;
  logic                r_clk_sync;
  logic                r_clk_prev;
  logic                r_data_meta;
  logic                r_data_sync;

  logic                w_fe;
  logic                w_to_active;
  logic                w_timeout;

  // Synchronizers reset to the idle (released, high) line level so no edge is seen after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_clk_meta  <= ps2Clk;
      r_clk_sync  <= r_clk_meta;
      r_clk_prev  <= r_clk_sync;
      r_data_meta <= ps2Data;
      r_data_sync <= r_data_meta;
    end
  end

  assign w_fe        = r_clk_prev & ~r_clk_sync;
  assign w_to_active = (r_state == S_SHIFT) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  assign w_timeout   = w_to_active && (r_to_cnt == c_TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_ack_ok   <= 1'b0;
      r_clk_low  <= 1'b0;
      r_data_low <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;

      if (w_to_active && !w_timeout) begin
        r_to_cnt <= r_to_cnt + c_TO_W'(1);
      end

      if (w_timeout) begin
        r_clk_low  <= 1'b0;
        r_data_low <= 1'b0;
        r_error    <= 1'b1;
        r_busy     <= 1'b0;
        r_state    <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              // Frame is shifted out LSB first: start, data[0..7], odd parity, stop.
              r_shift   <= {1'b1, ~^data, data, 1'b0};
              r_inh_cnt <= '0;
              r_clk_low <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= S_INHIBIT;
            end
          end

          S_INHIBIT: begin
            if (r_inh_cnt == c_INH_LAST) begin
              r_clk_low  <= 1'b0;
              r_data_low <= ~r_shift[0];
              r_state    <= S_REQUEST;
            end else begin
              r_inh_cnt <= r_inh_cnt + c_INH_W'(1);
            end
          end

          S_REQUEST: begin
            r_to_cnt  <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_SHIFT;
          end

          S_SHIFT: begin
            if (w_fe) begin
              r_shift    <= {1'b0, r_shift[10:1]};
              r_data_low <= ~r_shift[1];
              r_bit_cnt  <= r_bit_cnt + c_BIT_W'(1);
              if (r_bit_cnt == c_BIT_LAST) begin
                r_state <= S_ACK;
              end
            end
          end

          S_ACK: begin
            if (w_fe) begin
              r_ack_ok <= ~r_data_sync;
              r_state  <= S_WAIT_IDLE;
            end
          end

          S_WAIT_IDLE: begin
            if (r_clk_sync && r_data_sync) begin
              r_done  <= r_ack_ok;
              r_error <= ~r_ack_ok;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end

          default: begin
            r_clk_low  <= 1'b0;
            r_data_low <= 1'b0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ps2ClkDriveLow  = r_clk_low;
  assign ps2DataDriveLow = r_data_low;
  assign busy            = r_busy;
  assign done            = r_done;
  assign error           = r_error;

endmodule
`default_nettype wire
